// File: rtl/count_arb4_if.sv
// Bundle of requester handshakes and counter control lines around count_arb4.
// The slave side is the arbiter; the master side is the requesters plus the counter.
interface count_arb4_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] start0;
  logic [WIDTH-1:0] stop0;
  logic             req1;
  logic [WIDTH-1:0] start1;
  logic [WIDTH-1:0] stop1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_preset;
  logic             cnt_updown;
  logic [WIDTH-1:0] cnt_data_in;

  modport slave (
    input  req0, start0, stop0, req1, start1, stop1, cnt_q,
    output gnt0, gnt1, done0, done1, busy, cnt_preset, cnt_updown, cnt_data_in
  );

  modport master (
    output req0, start0, stop0, req1, start1, stop1, cnt_q,
    input  gnt0, gnt1, done0, done1, busy, cnt_preset, cnt_updown, cnt_data_in
  );
endinterface

// File: rtl/count_arb4.sv
// Round-robin controller for one shared enable-less loadable up/down counter:
// loads a requester's start value, steps toward its stop value, then holds.
module count_arb4 #(
  parameter int WIDTH = 4
) (
  input logic        mclk,
  input logic        reset,
  count_arb4_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic             owner;
  logic             last_served;
  logic             dir;
  logic [WIDTH-1:0] start_lat;
  logic [WIDTH-1:0] stop_lat;
  logic             accept;
  logic             pick;
  logic             at_stop;

  // With both requesting, the one not served last wins.
  always_comb begin
    accept = (state == IDLE) && (bus.req0 || bus.req1);
    if (bus.req0 && bus.req1)
      pick = ~last_served;
    else
      pick = bus.req1;
  end

  assign at_stop = (bus.cnt_q == stop_lat);

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      dir         <= 1'b0;
      start_lat   <= '0;
      stop_lat    <= '0;
    end else if (accept) begin
      owner       <= pick;
      last_served <= pick;
      start_lat   <= pick ? bus.start1 : bus.start0;
      stop_lat    <= pick ? bus.stop1 : bus.stop0;
      dir         <= pick ? (bus.stop1 > bus.start1) : (bus.stop0 > bus.start0);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (at_stop) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The counter has no enable, so holding means reloading its own output.
  always_comb begin
    bus.gnt0        = 1'b0;
    bus.gnt1        = 1'b0;
    bus.done0       = 1'b0;
    bus.done1       = 1'b0;
    bus.busy        = (state != IDLE);
    bus.cnt_preset  = 1'b0;
    bus.cnt_updown  = 1'b0;
    bus.cnt_data_in = bus.cnt_q;
    case (state)
      LOAD: begin
        bus.cnt_data_in = start_lat;
        bus.gnt0        = ~owner;
        bus.gnt1        = owner;
      end
      RUN: begin
        if (!at_stop) begin
          bus.cnt_preset = 1'b1;
          bus.cnt_updown = dir;
        end
      end
      DONE: begin
        bus.done0 = ~owner;
        bus.done1 = owner;
      end
      default: ;
    endcase
    if (!reset) begin
      bus.gnt0        = 1'b0;
      bus.gnt1        = 1'b0;
      bus.done0       = 1'b0;
      bus.done1       = 1'b0;
      bus.busy        = 1'b0;
      bus.cnt_preset  = 1'b0;
      bus.cnt_updown  = 1'b0;
      bus.cnt_data_in = '0;
    end
  end

endmodule
